// File: rtl/audio_sample_buffer_pkg.sv
// Shared types for the audio sample ring buffer.
// Holds the sample type and the states of the read-side fetch machine.
package audio_sample_buffer_pkg;

   typedef logic signed [23:0] sample_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_VALID
   } rd_state_e;

endpackage

// File: rtl/audio_sample_buffer_sample_ram.sv
// Simple dual-port sample store with one write port and one registered read port.
// The array has no reset, so synthesis can map it onto block RAM.
module sample_ram #(
   parameter int DATA_W = 24,
   parameter int DEPTH  = 256,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdData_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rdData_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rdData_q;

endmodule

// File: rtl/audio_sample_buffer.sv
// Ring buffer between the I2S receiver and the LED level meters.
// It banks filtered samples in block RAM and serves them over a valid/ready read port.
module audio_sample_buffer
   import audio_sample_buffer_pkg::*;
#(
   parameter int   DATA_W          = 24,
   parameter int   DEPTH           = 256,
   parameter logic SELECT_LEFT     = 1'b1,
   parameter logic CHAN_FILTER     = 1'b1,
   parameter int   READY_THRESHOLD = 64,
   localparam int  AW              = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              wr_valid_i,
   input  logic              wr_left_i,
   output logic [DATA_W-1:0] ram_read_data_o,
   output logic              ram_read_valid_o,
   input  logic              ram_read_ready_i,
   output logic              ram_buffer_ready_o,
   output logic [AW:0]       fill_level_o,
   output logic              overflow_o,
   input  logic              ovf_clr_i
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] THRESHOLD  = (AW+1)'(READY_THRESHOLD);

   rd_state_e         state_q, state_d;
   logic [AW-1:0]     wrPtr_q, wrPtr_d;
   logic [AW-1:0]     rdPtr_q, rdPtr_d;
   logic [AW:0]       count_q, count_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              bufReady_q, bufReady_d;
   logic              overflow_q, overflow_d;

   logic              writeAccept;
   logic              doWrite;
   logic              dropWrite;
   logic              rdEn;
   logic [DATA_W-1:0] ramData;

   assign writeAccept = wr_valid_i & (!CHAN_FILTER | (wr_left_i == SELECT_LEFT));
   assign doWrite     = writeAccept & (count_q != FULL_COUNT);
   assign dropWrite   = writeAccept & (count_q == FULL_COUNT);

   sample_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_sample_ram (
      .clk_i     (clk_i),
      .wr_en_i   (doWrite),
      .wr_addr_i (wrPtr_q),
      .wr_data_i (wr_data_i),
      .rd_en_i   (rdEn),
      .rd_addr_i (rdPtr_q),
      .rd_data_o (ramData)
   );

   // Only entries counted on an earlier cycle are read, so no write bypass is needed.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rdEn    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               rdEn    = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            data_d  = ramData;
            state_d = S_VALID;
         end
         S_VALID: begin
            if (ram_read_ready_i) begin
               if (count_q != '0) begin
                  rdEn    = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wrPtr_d    = doWrite ? wrPtr_q + AW'(1) : wrPtr_q;
      rdPtr_d    = rdEn ? rdPtr_q + AW'(1) : rdPtr_q;
      count_d    = count_q + (AW+1)'(doWrite) - (AW+1)'(rdEn);
      bufReady_d = bufReady_q;
      if (count_q >= THRESHOLD) begin
         bufReady_d = 1'b1;
      end else if ((count_q == '0) && (state_q != S_VALID)) begin
         bufReady_d = 1'b0;
      end
      overflow_d = overflow_q;
      if (dropWrite) begin
         overflow_d = 1'b1;
      end else if (ovf_clr_i) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         data_q     <= '0;
         bufReady_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         data_q     <= data_d;
         bufReady_q <= bufReady_d;
         overflow_q <= overflow_d;
      end
   end

   assign ram_read_data_o    = data_q;
   assign ram_read_valid_o   = (state_q == S_VALID);
   assign ram_buffer_ready_o = bufReady_q;
   assign fill_level_o       = count_q;
   assign overflow_o         = overflow_q;

endmodule
